// File: rtl/stream_mux_arb.sv
// N-input valid/ready stream multiplexer with external-select or round-robin
// channel choice, packet locking and a single registered output stage.
module stream_mux_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int MODE       = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0]            in_last,
  output logic [NUM_INPUTS-1:0]            in_ready,
  input  logic [SEL_WIDTH-1:0]             sel,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [SEL_WIDTH-1:0]             out_src,
  output logic                             out_valid,
  input  logic                             out_ready
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  localparam logic [SEL_WIDTH-1:0] RR_RESET = SEL_WIDTH'(NUM_INPUTS - 1);

  lock_state_t           state_reg, state_next;
  logic [SEL_WIDTH-1:0]  lock_idx_reg, lock_idx_next;
  logic [SEL_WIDTH-1:0]  rr_ptr_reg, rr_ptr_next;

  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_last_reg;
  logic [SEL_WIDTH-1:0]  out_src_reg;
  logic                  out_valid_reg;

  logic                  load;
  logic                  accept;
  logic                  gnt_valid;
  logic [SEL_WIDTH-1:0]  gnt_idx;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  gnt_last;

  assign load   = !out_valid_reg || out_ready;
  assign accept = rst_n && load && gnt_valid;

  // Out-of-range sel matches no channel in the loop, so it yields no grant.
  always_comb begin : grant_comb
    int cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    if (state_reg == LOCKED) begin
      gnt_idx = lock_idx_reg;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (lock_idx_reg == SEL_WIDTH'(i)) gnt_valid = in_valid[i];
      end
    end else if (MODE == 0) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (sel == SEL_WIDTH'(i)) begin
          gnt_idx   = sel;
          gnt_valid = in_valid[i];
        end
      end
    end else begin
      // Walk distances from farthest to nearest so the nearest valid channel after rr_ptr wins.
      for (int d = NUM_INPUTS; d >= 1; d--) begin
        cand = int'(rr_ptr_reg) + d;
        if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (cand == i && in_valid[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SEL_WIDTH'(i);
          end
        end
      end
    end
  end

  always_comb begin : beat_mux
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (gnt_idx == SEL_WIDTH'(i)) begin
        gnt_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_last = in_last[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
      assign in_ready[gi] = accept && (gnt_idx == SEL_WIDTH'(gi));
    end
  endgenerate

  always_comb begin : lock_fsm_comb
    state_next    = state_reg;
    lock_idx_next = lock_idx_reg;
    rr_ptr_next   = rr_ptr_reg;
    if (accept) begin
      if (gnt_last) begin
        state_next  = UNLOCKED;
        rr_ptr_next = gnt_idx;
      end else begin
        state_next    = LOCKED;
        lock_idx_next = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= UNLOCKED;
      lock_idx_reg  <= '0;
      rr_ptr_reg    <= RR_RESET;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_src_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lock_idx_reg <= lock_idx_next;
      rr_ptr_reg   <= rr_ptr_next;
      // Payload registers only move on an accepted beat; a drained slot keeps the last beat.
      if (load) begin
        if (accept) begin
          out_data_reg  <= gnt_data;
          out_last_reg  <= gnt_last;
          out_src_reg   <= gnt_idx;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_src   = out_src_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: three instances (select N=4, round-robin N=4, select N=3)
// share one stimulus and are checked every cycle against a cycle-level behavioural model.
module tb_stream_mux_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_last;
  logic [1:0]   sel;
  logic         out_ready;

  logic [3:0]   ir0, ir1;
  logic [2:0]   ir2;
  logic         ov [3];
  logic [31:0]  od [3];
  logic         ol [3];
  logic [1:0]   os [3];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what each instance's output register holds, plus lock and pointer.
  logic         mv  [3];
  logic [31:0]  md  [3];
  logic         ml  [3];
  int           ms  [3];
  bit           mlk [3];
  int           mli [3];
  int           mrr [3];
  bit           model_ok = 1'b0;

  always #5 clk = ~clk;

  stream_mux_arb #(.DATA_WIDTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir0), .sel(sel), .out_data(od[0]), .out_last(ol[0]), .out_src(os[0]),
    .out_valid(ov[0]), .out_ready(out_ready));

  stream_mux_arb #(.DATA_WIDTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir1), .sel(sel), .out_data(od[1]), .out_last(ol[1]), .out_src(os[1]),
    .out_valid(ov[1]), .out_ready(out_ready));

  stream_mux_arb #(.DATA_WIDTH(32), .NUM_INPUTS(3), .SEL_WIDTH(2), .MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]),
    .in_last(in_last[2:0]), .in_ready(ir2), .sel(sel), .out_data(od[2]), .out_last(ol[2]),
    .out_src(os[2]), .out_valid(ov[2]), .out_ready(out_ready));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Which channel the rules grant this cycle for instance k, and whether it is valid.
  function automatic void grant(input int k, output bit gv, output int gx);
    int n;
    int c;
    n  = (k == 2) ? 3 : 4;
    gv = 1'b0;
    gx = 0;
    if (mlk[k]) begin
      gx = mli[k];
      gv = in_valid[gx];
    end else if (k != 1) begin
      if (int'(sel) < n) begin
        gx = int'(sel);
        gv = in_valid[gx];
      end
    end else begin
      for (int j = 1; j <= n; j++) begin
        c = (mrr[k] + j) % n;
        if (!gv && in_valid[c]) begin
          gv = 1'b1;
          gx = c;
        end
      end
    end
  endfunction

  // Inputs change at posedge+1, so at negedge they are stable for the coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit         gv;
      int         gx;
      bit         ld;
      logic [3:0] er;
      logic [3:0] ar;
      grant(k, gv, gx);
      ld = !mv[k] || out_ready;
      er = (rst_n && ld && gv) ? (4'b0001 << gx) : 4'b0000;
      ar = (k == 0) ? ir0 : (k == 1) ? ir1 : {1'b0, ir2};
      if (model_ok) begin
        chk($sformatf("dut%0d.out_valid", k), 64'(ov[k]), 64'(mv[k]));
        chk($sformatf("dut%0d.out_data", k), 64'(od[k]), 64'(md[k]));
        chk($sformatf("dut%0d.out_last", k), 64'(ol[k]), 64'(ml[k]));
        chk($sformatf("dut%0d.out_src", k), 64'(os[k]), 64'(ms[k]));
        chk($sformatf("dut%0d.in_ready", k), 64'(ar), 64'(er));
      end
      if (!rst_n) begin
        mv[k]  <= 1'b0;
        md[k]  <= '0;
        ml[k]  <= 1'b0;
        ms[k]  <= 0;
        mlk[k] <= 1'b0;
        mli[k] <= 0;
        mrr[k] <= ((k == 2) ? 3 : 4) - 1;
      end else if (ld) begin
        if (gv) begin
          mv[k]  <= 1'b1;
          md[k]  <= in_data[gx*32 +: 32];
          ml[k]  <= in_last[gx];
          ms[k]  <= gx;
          mlk[k] <= !in_last[gx];
          if (in_last[gx]) mrr[k] <= gx;
          else             mli[k] <= gx;
        end else begin
          mv[k] <= 1'b0;
        end
      end
    end
    if (!rst_n) model_ok <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int ch, input logic [31:0] v);
    in_data[ch*32 +: 32] = v;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 4'b0100;
    in_last   = 4'b0100;
    sel       = 2'd2;
    out_ready = 1'b1;
    setd(2, 32'hA5A5_0001);

    // Reset and first-beat latency
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.in_ready", 64'(ir0), 64'h0);
      chk("rst.out_valid", 64'(ov[0]), 64'h0);
    end
    rst_n = 1'b1;
    #1 chk("lat.in_ready", 64'(ir0), 64'h4);
    tick();
    chk("lat.out_valid", 64'(ov[0]), 64'h1);
    chk("lat.out_data", 64'(od[0]), 64'hA5A5_0001);
    chk("lat.out_src", 64'(os[0]), 64'h2);

    // Backpressure on a 4-beat ch1 packet
    in_valid = 4'b0000;
    tick();
    sel = 2'd1; in_valid = 4'b0010; in_last = 4'b0000; setd(1, 32'hB000_0000);
    #1 chk("bp.ready0", 64'(ir0), 64'h2);
    tick();
    out_ready = 1'b0; setd(1, 32'hB000_0001);
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bp.stall_ready", 64'(ir0), 64'h0);
      chk("bp.stall_data", 64'(od[0]), 64'hB000_0000);
      chk("bp.stall_valid", 64'(ov[0]), 64'h1);
      tick();
    end
    out_ready = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      setd(1, 32'hB000_0000 + 32'(b));
      in_last = (b == 3) ? 4'b0010 : 4'b0000;
      #1 chk("bp.ready", 64'(ir0), 64'h2);
      tick();
      chk("bp.data", 64'(od[0]), 64'hB000_0000 + 64'(b));
      chk("bp.last", 64'(ol[0]), (b == 3) ? 64'h1 : 64'h0);
    end

    // Round-robin fairness with single-beat packets
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    for (int i = 0; i < 4; i++) setd(i, 32'hC0 + 32'(i));
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rr.out_src", 64'(os[1]), 64'(c % 4));
      chk("rr.out_data", 64'(od[1]), 64'hC0 + 64'(c % 4));
    end

    // Packet lock with a 2-cycle gap on ch0
    in_last = 4'b1110; setd(0, 32'hE0);
    tick();
    chk("lock.src0", 64'(os[1]), 64'h0);
    in_valid = 4'b1110;
    for (int g = 0; g < 2; g++) begin
      #1 chk("lock.gap_ready", 64'(ir1), 64'h0);
      tick();
      chk("lock.bubble", 64'(ov[1]), 64'h0);
    end
    in_valid = 4'b1111; setd(0, 32'hE1);
    tick();
    chk("lock.src1", 64'(os[1]), 64'h0);
    chk("lock.data1", 64'(od[1]), 64'hE1);
    setd(0, 32'hE2); in_last = 4'b1111;
    #1 chk("lock.ready2", 64'(ir1), 64'h1);
    tick();
    chk("lock.last", 64'(ol[1]), 64'h1);
    tick();
    chk("lock.next_src", 64'(os[1]), 64'h1);

    // Select change mid-packet on the external-select instance
    sel = 2'd1; in_valid = 4'b1010; in_last = 4'b1000; setd(3, 32'h33);
    for (int b = 0; b < 4; b++) begin
      setd(1, 32'hF0 + 32'(b));
      if (b == 2) sel = 2'd3;
      if (b == 3) in_last = 4'b1010;
      #1 chk("sel.ready", 64'(ir0), 64'h2);
      tick();
      chk("sel.src", 64'(os[0]), 64'h1);
      chk("sel.data", 64'(od[0]), 64'hF0 + 64'(b));
    end
    #1 chk("sel.ch3_ready", 64'(ir0), 64'h8);
    tick();
    chk("sel.ch3_src", 64'(os[0]), 64'h3);

    // Out-of-range select and reset while locked (3-channel instance)
    sel = 2'd3; in_valid = 4'b1111; in_last = 4'b1111;
    tick();
    for (int s = 0; s < 2; s++) begin
      #1 chk("oor.ready", 64'(ir2), 64'h0);
      tick();
      chk("oor.out_valid", 64'(ov[2]), 64'h0);
    end
    sel = 2'd2; in_last = 4'b1011; setd(2, 32'h2A);
    #1 chk("mid.ready", 64'(ir2), 64'h4);
    tick();
    chk("mid.src", 64'(os[2]), 64'h2);
    rst_n = 1'b0;
    #1 chk("mid.rst_ready", 64'(ir2), 64'h0);
    tick();
    chk("mid.rst_valid", 64'(ov[2]), 64'h0);
    rst_n = 1'b1; sel = 2'd1; in_last = 4'b1111; setd(1, 32'h11);
    #1 chk("mid.regrant", 64'(ir2), 64'h2);
    tick();
    chk("mid.src_after", 64'(os[2]), 64'h1);
    chk("mid.data_after", 64'(od[2]), 64'h11);

    // Randomized traffic, checked by the per-cycle model
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        in_last[i] = ($urandom_range(0, 2) == 0);
        setd(i, $urandom);
      end
      tick();
    end
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised N-input streaming multiplexer with a valid/ready handshake on every input and on the output.
- Merges several producer streams (fetch/LSU request channels, debug taps) onto one consumer.
- Two channel-selection modes: an externally driven select, or internal round-robin arbitration.
- Packet locking keeps a multi-beat transfer contiguous. The output is registered, giving 1-cycle latency and full throughput.

Parameters:
- DATA_WIDTH, 32, width of each data beat.
- NUM_INPUTS, 4, number of input channels, 1..16.
- SEL_WIDTH, 2, width of sel/out_src. Must satisfy 2**SEL_WIDTH >= NUM_INPUTS and SEL_WIDTH >= 1.
- MODE, 0, channel selection. 0 = external select via sel; 1 = round-robin arbitration, sel ignored.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- in_data  input  NUM_INPUTS*DATA_WIDTH  flattened beats; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  NUM_INPUTS  per-channel beat valid
- in_last  input  NUM_INPUTS  per-channel end-of-packet flag, qualified by in_valid
- in_ready  output  NUM_INPUTS  per-channel accept (combinational)
- sel  input  SEL_WIDTH  channel select, used in MODE 0 only
- out_data  output  DATA_WIDTH  registered beat
- out_last  output  1  registered end-of-packet flag
- out_src  output  SEL_WIDTH  index of the channel that produced out_data
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer accept

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk.
  - Reset values: out_valid=0, out_data=0, out_last=0, out_src=0, lock state UNLOCKED, rr_ptr=NUM_INPUTS-1.
  - in_ready is forced to all-zero while rst_n=0.
- Load condition: load = !out_valid || out_ready. This gives a single register stage with no bubble under continuous flow.
- Grant logic (combinational), producing gnt_valid and gnt_idx:
  - LOCKED: gnt_idx = lock_idx; gnt_valid = in_valid[lock_idx]. Other channels are never granted; sel is ignored.
  - UNLOCKED, MODE 0: if sel < NUM_INPUTS then gnt_idx = sel and gnt_valid = in_valid[sel]; otherwise gnt_valid = 0.
  - UNLOCKED, MODE 1: gnt_idx is the first i with in_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_INPUTS. gnt_valid = 0 if no channel is valid.
- Handshake:
  - in_ready[i] = rst_n && load && (i == gnt_idx) && gnt_valid-eligibility. At most one bit of in_ready is set per cycle.
  - A beat is accepted when in_valid[i] && in_ready[i]. in_ready never depends on data content.
- Accept cycle, next edge:
  - out_data <= beat; out_last <= in_last[gnt_idx]; out_src <= gnt_idx; out_valid <= 1.
- Load without accept: out_valid <= 0. out_data, out_last and out_src hold their last values.
- !load: all output registers hold. out_data, out_last and out_src are stable while out_valid && !out_ready.
- Lock FSM:
  - UNLOCKED -> LOCKED on accepting a beat with in_last=0; lock_idx <= gnt_idx.
  - LOCKED -> UNLOCKED on accepting a beat with in_last=1.
  - A single-beat packet (in_last=1 on the first beat) stays UNLOCKED.
- rr_ptr <= gnt_idx on every accepted beat with in_last=1, in both modes. It is unused in MODE 0.
- Boundary conditions:
  - Locked channel drops in_valid mid-packet: the lock holds, output bubbles, no other channel is granted.
  - Select changes mid-packet (MODE 0): ignored until packet end.
  - Out-of-range sel: no grant, all in_ready=0.
  - NUM_INPUTS=1: channel 0 is always granted, and rr_ptr wrap is trivially 0.
  - Simultaneous output drain and refill in one cycle: allowed, giving full throughput.
  - Reset mid-packet: lock cleared, pending output beat discarded.

Test Plan:
1. Reset and latency: MODE 0, sel=2, in_valid=4'b0100, data ch2=0xA5A5_0001, last=1, out_ready=1, rst_n released at cycle 0 -> in_ready=4'b0100 at cycle 0; out_valid=1, out_data=0xA5A5_0001, out_src=2 at cycle 1; in_ready=0 during reset.
2. Backpressure: stream 4 beats from ch1 with out_ready held 0 for 3 cycles after the first beat -> out_data stays at beat 0 and in_ready[1]=0 during the stall; after release, beats 1..3 appear on consecutive cycles with none lost or duplicated.
3. Round-robin fairness: MODE 1, all 4 channels continuously valid with single-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0,1...
4. Packet lock: MODE 1, ch0 sends a 3-beat packet (last on beat 3) while ch1..3 are valid; ch0 drops valid for 2 cycles mid-packet -> out_src=0 for all 3 beats, 2-cycle bubble, ch1 granted only after ch0's last beat.
5. Select change mid-packet: MODE 0, sel switches 1->3 after beat 1 of a 4-beat ch1 packet -> remaining beats come from ch1; ch3 first accepted the cycle after ch1's last beat.
6. Reset mid-packet and out-of-range select: NUM_INPUTS=3, sel=3 -> in_ready=0, out_valid stays 0. Assert rst_n=0 while locked on ch2 -> next cycle out_valid=0 and lock cleared; the next packet is granted per sel.
